// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the next-PC sequencer: FSM state encodings, PC step, NOP word.
package pc_seq_pkg;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;

  localparam int unsigned PC_INC = 4;

  // Encoded NOP (sll $0,$0,0) the pipeline uses for bubbles and flushed slots.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Wide enough for LU_STALL_CYC up to 7.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Pipeline-control bundle between the next-PC sequencer (master) and the datapath (slave).
interface pc_sequencer_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic [DATA_W-1:0]     pc_cur_i;
  logic                  imem_ready_i;
  logic                  ex_memread_i;
  logic [REG_ADDR_W-1:0] ex_rt_i;
  logic [REG_ADDR_W-1:0] id_rs_i;
  logic [REG_ADDR_W-1:0] id_rt_i;
  logic                  branch_taken_i;
  logic [DATA_W-1:0]     branch_target_i;
  logic                  jump_i;
  logic [DATA_W-1:0]     jump_target_i;
  logic [DATA_W-1:0]     pc_next_o;
  logic                  pcwrite_o;
  logic                  ifid_write_o;
  logic                  ifid_flush_o;
  logic                  idex_bubble_o;
  logic [31:0]           stall_cnt_o;
  logic [31:0]           flush_cnt_o;

  modport master (
    input  pc_cur_i, imem_ready_i, ex_memread_i, ex_rt_i, id_rs_i, id_rt_i,
           branch_taken_i, branch_target_i, jump_i, jump_target_i,
    output pc_next_o, pcwrite_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    output pc_cur_i, imem_ready_i, ex_memread_i, ex_rt_i, id_rs_i, id_rt_i,
           branch_taken_i, branch_target_i, jump_i, jump_target_i,
    input  pc_next_o, pcwrite_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pc_sequencer_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources of ID.
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  always_comb begin
    load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: redirect > load-use stall > I-mem wait > PC+4, with pending-redirect hold.
// Optional perf counters are built only when PC_SEQ_PERF_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       REG_ADDR_W   = 5,
  parameter logic [DATA_W-1:0] RESET_PC     = '0,
  parameter int unsigned       LU_STALL_CYC = 1
) (
  input logic           clk_i,
  input logic           rst_n,
  pc_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] LU_CNT_INIT = CNT_W'(LU_STALL_CYC - 1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] pend_pc, pend_nxt;
  logic              load_use;
  logic              redirect;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] pc_seq;
  logic [DATA_W-1:0] pc_next;
  logic              pcwrite, ifid_write, ifid_flush, idex_bubble;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .ex_memread (bus.ex_memread_i),
    .ex_rt      (bus.ex_rt_i),
    .id_rs      (bus.id_rs_i),
    .id_rt      (bus.id_rt_i),
    .load_use   (load_use)
  );

  always_comb begin
    redirect    = bus.branch_taken_i | bus.jump_i;
    target      = bus.branch_taken_i ? bus.branch_target_i : bus.jump_target_i;
    pc_seq      = bus.pc_cur_i + DATA_W'(PC_INC);
    pc_next     = pc_seq;
    pcwrite     = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend_pc;

    if (state == S_PEND) begin
      ifid_flush = 1'b1;
      pc_next    = pend_pc;
      if (redirect) begin
        pc_next = target;
        if (bus.imem_ready_i) begin
          pcwrite   = 1'b1;
          state_nxt = S_RUN;
        end else begin
          pend_nxt = target;
        end
      end else if (bus.imem_ready_i) begin
        pcwrite   = 1'b1;
        state_nxt = S_RUN;
      end
    end else if (redirect) begin
      // Same handling from RUN and STALL: a redirect aborts any stall in progress.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pc_next     = target;
      if (bus.imem_ready_i) begin
        pcwrite   = 1'b1;
        state_nxt = S_RUN;
      end else begin
        pend_nxt  = target;
        state_nxt = S_PEND;
      end
    end else if (state == S_STALL) begin
      idex_bubble = 1'b1;
      cnt_nxt     = cnt - 1'b1;
      if (cnt <= CNT_W'(1)) state_nxt = S_RUN;
    end else if (load_use) begin
      idex_bubble = 1'b1;
      cnt_nxt     = LU_CNT_INIT;
      state_nxt   = (LU_STALL_CYC > 1) ? S_STALL : S_RUN;
    end else begin
      pcwrite    = bus.imem_ready_i;
      ifid_write = bus.imem_ready_i;
    end

    if (!rst_n) begin
      pc_next     = RESET_PC;
      pcwrite     = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RUN;
      cnt     <= '0;
      pend_pc <= RESET_PC;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_pc <= pend_nxt;
    end
  end

  always_comb begin
    bus.pc_next_o     = pc_next;
    bus.pcwrite_o     = pcwrite;
    bus.ifid_write_o  = ifid_write;
    bus.ifid_flush_o  = ifid_flush;
    bus.idex_bubble_o = idex_bubble;
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pcwrite && !redirect && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (redirect && (flush_cnt != '1))              flush_cnt <= flush_cnt + 32'd1;
    end
  end

  always_comb begin
    bus.stall_cnt_o = stall_cnt;
    bus.flush_cnt_o = flush_cnt;
  end
`else
  always_comb begin
    bus.stall_cnt_o = '0;
    bus.flush_cnt_o = '0;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (LU_STALL_CYC=2, non-zero RESET_PC).
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  pc_sequencer #(
    .DATA_W       (32),
    .REG_ADDR_W   (5),
    .RESET_PC     (RST_PC),
    .LU_STALL_CYC (2)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.ex_memread_i   = 1'b0;
    bus.ex_rt_i        = '0;
    bus.id_rs_i        = '0;
    bus.id_rt_i        = '0;
    bus.branch_taken_i = 1'b0;
    bus.jump_i         = 1'b0;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.pc_cur_i        = '0;
    bus.imem_ready_i    = 1'b1;
    bus.branch_target_i = '0;
    bus.jump_target_i   = '0;
    clear_ctl();
    #1;
    check("rst_pc_next", bus.pc_next_o, RST_PC);
    check("rst_pcwrite", 32'(bus.pcwrite_o), 0);
    check("rst_ifid_write", 32'(bus.ifid_write_o), 0);
    check("rst_flush", 32'(bus.ifid_flush_o), 0);
    check("rst_bubble", 32'(bus.idex_bubble_o), 0);
    check("rst_stall_cnt", bus.stall_cnt_o, 0);
    check("rst_flush_cnt", bus.flush_cnt_o, 0);

    // Sequential fetch
    tick(); rst_n = 1'b1; #1;
    check("seq0_pc_next", bus.pc_next_o, 32'h4);
    check("seq0_pcwrite", 32'(bus.pcwrite_o), 1);
    check("seq0_ifid_write", 32'(bus.ifid_write_o), 1);
    tick(); bus.pc_cur_i = 32'h4; #1;
    check("seq1_pc_next", bus.pc_next_o, 32'h8);
    tick(); bus.pc_cur_i = 32'h8; #1;
    check("seq2_pc_next", bus.pc_next_o, 32'hC);

    // Load-use on rs: two stall cycles, then resume
    tick(); bus.pc_cur_i = 32'h10;
    bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd5; bus.id_rs_i = 5'd5; #1;
    check("lu1_pcwrite", 32'(bus.pcwrite_o), 0);
    check("lu1_ifid_write", 32'(bus.ifid_write_o), 0);
    check("lu1_bubble", 32'(bus.idex_bubble_o), 1);
    tick(); clear_ctl(); #1;
    check("lu2_pcwrite", 32'(bus.pcwrite_o), 0);
    check("lu2_bubble", 32'(bus.idex_bubble_o), 1);
    tick(); #1;
    check("lu3_pcwrite", 32'(bus.pcwrite_o), 1);
    check("lu3_pc_next", bus.pc_next_o, 32'h14);
    check("lu3_bubble", 32'(bus.idex_bubble_o), 0);

    // Load into r0 never stalls
    tick(); bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd0; #1;
    check("lu_r0_pcwrite", 32'(bus.pcwrite_o), 1);
    check("lu_r0_bubble", 32'(bus.idex_bubble_o), 0);

    // Branch beats load-use and jump in the same cycle
    tick(); bus.ex_rt_i = 5'd5; bus.id_rs_i = 5'd5;
    bus.branch_taken_i = 1'b1; bus.branch_target_i = 32'h40;
    bus.jump_i = 1'b1; bus.jump_target_i = 32'h80; #1;
    check("br_pc_next", bus.pc_next_o, 32'h40);
    check("br_pcwrite", 32'(bus.pcwrite_o), 1);
    check("br_flush", 32'(bus.ifid_flush_o), 1);
    tick(); clear_ctl(); bus.pc_cur_i = 32'h40; #1;
    check("br_after_pc_next", bus.pc_next_o, 32'h44);
    check("br_after_pcwrite", 32'(bus.pcwrite_o), 1);
`ifdef PC_SEQ_PERF_EN
    check("perf_stall_cnt", bus.stall_cnt_o, 2);
    check("perf_flush_cnt", bus.flush_cnt_o, 1);
`else
    check("perf_off_stall_cnt", bus.stall_cnt_o, 0);
    check("perf_off_flush_cnt", bus.flush_cnt_o, 0);
`endif

    // Load-use on rt
    tick(); bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd7; bus.id_rs_i = 5'd3; bus.id_rt_i = 5'd7; #1;
    check("lurt_pcwrite", 32'(bus.pcwrite_o), 0);
    check("lurt_bubble", 32'(bus.idex_bubble_o), 1);
    tick(); clear_ctl(); #1;
    check("lurt2_bubble", 32'(bus.idex_bubble_o), 1);
    tick(); #1;
    check("lurt3_pcwrite", 32'(bus.pcwrite_o), 1);

    // Jump while I-mem busy for three cycles
    tick(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h100; bus.imem_ready_i = 1'b0; #1;
    check("jp1_pcwrite", 32'(bus.pcwrite_o), 0);
    check("jp1_flush", 32'(bus.ifid_flush_o), 1);
    tick(); bus.jump_i = 1'b0; #1;
    check("jp2_pcwrite", 32'(bus.pcwrite_o), 0);
    check("jp2_flush", 32'(bus.ifid_flush_o), 1);
    tick(); #1;
    check("jp3_pcwrite", 32'(bus.pcwrite_o), 0);
    check("jp3_flush", 32'(bus.ifid_flush_o), 1);
    tick(); bus.imem_ready_i = 1'b1; #1;
    check("jp4_pc_next", bus.pc_next_o, 32'h100);
    check("jp4_pcwrite", 32'(bus.pcwrite_o), 1);
    tick(); bus.pc_cur_i = 32'h100; #1;
    check("jp5_pc_next", bus.pc_next_o, 32'h104);
    check("jp5_flush", 32'(bus.ifid_flush_o), 0);

    // Newer redirect overwrites a pending one
    tick(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h200; bus.imem_ready_i = 1'b0;
    tick(); bus.jump_i = 1'b0; bus.branch_taken_i = 1'b1; bus.branch_target_i = 32'h300;
    tick(); bus.branch_taken_i = 1'b0; bus.imem_ready_i = 1'b1; #1;
    check("ovr_pc_next", bus.pc_next_o, 32'h300);
    check("ovr_pcwrite", 32'(bus.pcwrite_o), 1);

    // Wrap-around
    tick(); bus.pc_cur_i = 32'hFFFF_FFFC; #1;
    check("wrap_pc_next", bus.pc_next_o, 32'h0);

    // Async reset while pending, then no stale redirect
    tick(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h500; bus.imem_ready_i = 1'b0;
    tick(); bus.jump_i = 1'b0; #1;
    check("pend_flush", 32'(bus.ifid_flush_o), 1);
    #1; rst_n = 1'b0; #1;
    check("arst_pc_next", bus.pc_next_o, RST_PC);
    check("arst_pcwrite", 32'(bus.pcwrite_o), 0);
    check("arst_flush", 32'(bus.ifid_flush_o), 0);
    tick(); rst_n = 1'b1; bus.imem_ready_i = 1'b1; bus.pc_cur_i = 32'h20; #1;
    check("post_rst_pc_next", bus.pc_next_o, 32'h24);
    check("post_rst_pcwrite", 32'(bus.pcwrite_o), 1);
    check("post_rst_flush", 32'(bus.ifid_flush_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
